// File: rtl/fetch_unit_if.sv
// Instruction memory read handshake between fetch_unit (master) and memory (slave).
interface fetch_unit_if #(
  parameter int unsigned WORD = 16
);
  logic            req;
  logic [WORD-1:0] addr;
  logic            ack;
  logic [WORD-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads PC, runs a variable-latency memory read, loads the IR,
// then writes PC + PC_INC back through the register file PC port.
module fetch_unit #(
  parameter int unsigned WORD   = 16,
  parameter int unsigned PC_INC = 2
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            fetch_i,
  input  logic            flush_i,
  input  logic [WORD-1:0] pc_i,
  fetch_unit_if.master    mem,
  output logic            pcen_o,
  output logic [WORD-1:0] pc_o,
  output logic [WORD-1:0] ir_o,
  output logic            ir_valid_o,
  output logic            busy_o,
  output logic            fault_o
);

  localparam logic [WORD-1:0] IncW = WORD'(PC_INC);

  typedef enum logic [1:0] {StIdle, StReq, StUpdate, StFault} state_e;

  state_e          state_q;
  logic            mem_req_q;
  logic [WORD-1:0] addr_q;
  logic            pcen_q;
  logic [WORD-1:0] pc_q;
  logic [WORD-1:0] ir_q;
  logic            ir_valid_q;
  logic            busy_q;
  logic            fault_q;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q    <= StIdle;
      mem_req_q  <= 1'b0;
      addr_q     <= '0;
      pcen_q     <= 1'b0;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush_i) begin
            ir_valid_q <= 1'b0;
          end else if (fetch_i) begin
            ir_valid_q <= 1'b0;
            if (pc_i[0]) begin
              fault_q <= 1'b1;
              state_q <= StFault;
            end else begin
              addr_q    <= pc_i;
              mem_req_q <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= StReq;
            end
          end
        end
        StReq: begin
          // Flush beats a same-cycle ack; the returned word is dropped.
          if (flush_i) begin
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            ir_valid_q <= 1'b0;
            state_q    <= StIdle;
          end else if (mem.ack) begin
            mem_req_q  <= 1'b0;
            ir_q       <= mem.rdata;
            ir_valid_q <= 1'b1;
            pcen_q     <= 1'b1;
            pc_q       <= addr_q + IncW;
            state_q    <= StUpdate;
          end
        end
        StUpdate: begin
          pcen_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        StFault: begin
          if (flush_i) begin
            fault_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem.req    = mem_req_q;
  assign mem.addr   = addr_q;
  assign pcen_o     = pcen_q;
  assign pc_o       = pc_q;
  assign ir_o       = ir_q;
  assign ir_valid_o = ir_valid_q;
  assign busy_o     = busy_q;
  assign fault_o    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        fetch_i;
  logic        flush_i;
  logic [15:0] pc_i;
  logic        pcen_o;
  logic [15:0] pc_o;
  logic [15:0] ir_o;
  logic        ir_valid_o;
  logic        busy_o;
  logic        fault_o;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt;
  int req_seen;

  fetch_unit_if #(.WORD(16)) mem_if ();

  fetch_unit #(
    .WORD  (16),
    .PC_INC(2)
  ) dut (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .fetch_i   (fetch_i),
    .flush_i   (flush_i),
    .pc_i      (pc_i),
    .mem       (mem_if.master),
    .pcen_o    (pcen_o),
    .pc_o      (pc_o),
    .ir_o      (ir_o),
    .ir_valid_o(ir_valid_o),
    .busy_o    (busy_o),
    .fault_o   (fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    arst_i        = 1'b0;
    fetch_i       = 1'b0;
    flush_i       = 1'b0;
    pc_i          = '0;
    mem_if.ack    = 1'b0;
    mem_if.rdata  = '0;
    #12;
    check("rst_req",   32'(mem_if.req), 0);
    check("rst_addr",  32'(mem_if.addr), 0);
    check("rst_pcen",  32'(pcen_o), 0);
    check("rst_pc",    32'(pc_o), 0);
    check("rst_ir",    32'(ir_o), 0);
    check("rst_irv",   32'(ir_valid_o), 0);
    check("rst_busy",  32'(busy_o), 0);
    check("rst_fault", 32'(fault_o), 0);
    step();
    arst_i = 1'b1;
    step();

    // Asynchronous reset in the middle of a request.
    pc_i = 16'h0100; fetch_i = 1'b1;
    step();
    fetch_i = 1'b0;
    check("midreq_req",  32'(mem_if.req), 1);
    check("midreq_busy", 32'(busy_o), 1);
    #3 arst_i = 1'b0;
    #1;
    check("arst_req",  32'(mem_if.req), 0);
    check("arst_addr", 32'(mem_if.addr), 0);
    check("arst_busy", 32'(busy_o), 0);
    step();
    arst_i = 1'b1;
    req_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (mem_if.req) req_seen++;
    end
    check("post_rst_noreq", 32'(req_seen), 0);

    // Zero-wait fetch.
    pc_i = 16'h0100; fetch_i = 1'b1;
    step();
    fetch_i = 1'b0;
    check("f1_req",  32'(mem_if.req), 1);
    check("f1_addr", 32'(mem_if.addr), 32'h0100);
    check("f1_busy", 32'(busy_o), 1);
    mem_if.ack = 1'b1; mem_if.rdata = 16'hA5C3;
    step();
    mem_if.ack = 1'b0;
    check("f1_ir",   32'(ir_o), 32'hA5C3);
    check("f1_irv",  32'(ir_valid_o), 1);
    check("f1_pcen", 32'(pcen_o), 1);
    check("f1_pc",   32'(pc_o), 32'h0102);
    check("f1_req0", 32'(mem_if.req), 0);
    step();
    check("f1_pcen0", 32'(pcen_o), 0);
    check("f1_pchold", 32'(pc_o), 32'h0102);
    check("f1_idle", 32'(busy_o), 0);

    // Four wait states; PC input changes mid-fetch.
    pc_i = 16'h0200; fetch_i = 1'b1;
    step();
    fetch_i = 1'b0;
    pc_i = 16'h0300;
    busy_cnt = busy_o ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (busy_o) busy_cnt++;
      check("f2_addr_hold", 32'(mem_if.addr), 32'h0200);
      check("f2_req_hold",  32'(mem_if.req), 1);
    end
    mem_if.ack = 1'b1; mem_if.rdata = 16'h5A5A;
    step();
    mem_if.ack = 1'b0;
    if (busy_o) busy_cnt++;
    check("f2_pc", 32'(pc_o), 32'h0202);
    check("f2_ir", 32'(ir_o), 32'h5A5A);
    step();
    if (busy_o) busy_cnt++;
    check("f2_busy_cycles", 32'(busy_cnt), 6);

    // PC wrap.
    pc_i = 16'hFFFE; fetch_i = 1'b1;
    step();
    fetch_i = 1'b0;
    mem_if.ack = 1'b1; mem_if.rdata = 16'h1234;
    step();
    mem_if.ack = 1'b0;
    check("wrap_pc",   32'(pc_o), 0);
    check("wrap_ir",   32'(ir_o), 32'h1234);
    check("wrap_pcen", 32'(pcen_o), 1);
    step();

    // Flush wins over a same-cycle ack.
    pc_i = 16'h0400; fetch_i = 1'b1;
    step();
    fetch_i = 1'b0;
    mem_if.ack = 1'b1; flush_i = 1'b1; mem_if.rdata = 16'hDEAD;
    step();
    mem_if.ack = 1'b0; flush_i = 1'b0;
    check("flush_ir",   32'(ir_o), 32'h1234);
    check("flush_irv",  32'(ir_valid_o), 0);
    check("flush_pcen", 32'(pcen_o), 0);
    check("flush_busy", 32'(busy_o), 0);
    check("flush_req",  32'(mem_if.req), 0);
    step();
    check("flush_pcen2", 32'(pcen_o), 0);
    check("flush_pc",    32'(pc_o), 0);

    // Misaligned PC fault.
    pc_i = 16'h0101; fetch_i = 1'b1;
    step();
    check("fault_set",  32'(fault_o), 1);
    check("fault_busy", 32'(busy_o), 0);
    check("fault_irv",  32'(ir_valid_o), 0);
    req_seen = mem_if.req ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (mem_if.req) req_seen++;
    end
    check("fault_noreq", 32'(req_seen), 0);
    check("fault_hold",  32'(fault_o), 1);
    fetch_i = 1'b0; flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("fault_clr", 32'(fault_o), 0);
    pc_i = 16'h0010; fetch_i = 1'b1;
    step();
    fetch_i = 1'b0;
    check("af_req",  32'(mem_if.req), 1);
    check("af_addr", 32'(mem_if.addr), 32'h0010);
    mem_if.ack = 1'b1; mem_if.rdata = 16'h0F0F;
    step();
    mem_if.ack = 1'b0;
    check("af_ir",  32'(ir_o), 32'h0F0F);
    check("af_pc",  32'(pc_o), 32'h0012);
    check("af_irv", 32'(ir_valid_o), 1);
    step();

    // Flush in IDLE clears ir_valid and beats fetch.
    flush_i = 1'b1; fetch_i = 1'b1; pc_i = 16'h0020;
    step();
    flush_i = 1'b0; fetch_i = 1'b0;
    check("idle_flush_irv", 32'(ir_valid_o), 0);
    check("idle_flush_req", 32'(mem_if.req), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
